// File: rtl/bsg_fifo_credit_sender_pkg.sv
// rtl/bsg_fifo_credit_sender_pkg.sv - shared types and width helpers for the credit sender
package bsg_fifo_credit_sender_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } bsg_fifo_credit_sender_state_e;

  localparam int default_width_lp = 32;
  localparam int default_els_lp   = 64;

  // Remote slot index width; the receive-side tracker wrappers use the same helper
  function automatic int ptr_width(input int els);
    return (els <= 1) ? 1 : $clog2(els);
  endfunction

  // Occupancy/credit width, wide enough to hold the value els itself
  function automatic int cnt_width(input int els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_fifo_credit_sender_if.sv
// rtl/bsg_fifo_credit_sender_if.sv - producer handshake plus credit link bundle
interface bsg_fifo_credit_sender_if
  import bsg_fifo_credit_sender_pkg::*;
#(
  parameter int width_p = default_width_lp,
  parameter int els_p   = default_els_lp
);
  localparam int ptr_width_lp = ptr_width(els_p);

  logic                    v_i;
  logic [width_p-1:0]      data_i;
  logic                    ready_o;
  logic                    v_o;
  logic [width_p-1:0]      data_o;
  logic [ptr_width_lp-1:0] wptr_o;
  logic                    credit_i;

  // master: producer plus remote receiver; slave: the sender
  modport master (output v_i, data_i, credit_i, input ready_o, v_o, data_o, wptr_o);
  modport slave  (input v_i, data_i, credit_i, output ready_o, v_o, data_o, wptr_o);

endinterface

// File: rtl/bsg_credit_counter_up_down.sv
// rtl/bsg_credit_counter_up_down.sv - credit register with batch return, saturation and overflow flag
module bsg_credit_counter_up_down #(
  parameter int max_p   = 64,
  parameter int batch_p = 1,
  parameter int width_p = 7
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               down_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o,
  output logic               overflow_o
);

  localparam logic [width_p:0] max_lp   = (width_p + 1)'(max_p);
  localparam logic [width_p:0] batch_lp = (width_p + 1)'(batch_p);

  logic [width_p:0] sum;

  // One extra bit so a return on top of a full count shows up as > max instead of wrapping;
  // a decrement at zero also wraps high and is therefore caught by the same compare
  always_comb begin
    sum = {1'b0, count_o} - {{width_p{1'b0}}, down_i} + (up_i ? batch_lp : '0);
  end

  // Count starts full (remote empty); excess returns saturate and raise a sticky flag
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o    <= max_lp[width_p-1:0];
      overflow_o <= 1'b0;
    end else if (sum > max_lp) begin
      count_o    <= max_lp[width_p-1:0];
      overflow_o <= 1'b1;
    end else begin
      count_o    <= sum[width_p-1:0];
    end
  end

endmodule

// File: rtl/bsg_fifo_credit_sender.sv
// rtl/bsg_fifo_credit_sender.sv - credit-flow sender feeding a remote receive FIFO over a valid-only link
module bsg_fifo_credit_sender
  import bsg_fifo_credit_sender_pkg::*;
#(
  parameter int width_p        = default_width_lp,
  parameter int els_p          = default_els_lp,
  parameter int credit_batch_p = 1,
  localparam int ptr_width_lp  = ptr_width(els_p),
  localparam int cnt_width_lp  = cnt_width(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bsg_fifo_credit_sender_if.slave link,
  input  logic                    drain_i,
  output logic                    idle_o,
  output logic [cnt_width_lp-1:0] credits_o,
  output logic                    error_o
);

  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

  bsg_fifo_credit_sender_state_e state, state_n;
  logic [ptr_width_lp-1:0]       wptr;
  logic                          ready;
  logic                          send;

  // Ready depends only on state and credits so the producer never sees a combinational loop
  assign ready        = (state == RUN) && (credits_o != '0);
  assign link.ready_o = ready;
  assign send         = link.v_i & ready;
  assign idle_o       = (state == IDLE);

  bsg_credit_counter_up_down #(
    .max_p   (els_p),
    .batch_p (credit_batch_p),
    .width_p (cnt_width_lp)
  ) credit_counter (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .down_i     (send),
    .up_i       (link.credit_i),
    .count_o    (credits_o),
    .overflow_o (error_o)
  );

  // Link register and write-pointer mirror; pointer wraps at els_p-1 to track non-power-of-two depths
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr        <= '0;
      link.v_o    <= 1'b0;
      link.data_o <= '0;
      link.wptr_o <= '0;
    end else begin
      link.v_o <= send;
      if (send) begin
        link.data_o <= link.data_i;
        link.wptr_o <= wptr;
        wptr        <= (wptr == last_ptr_lp) ? '0 : wptr + 1'b1;
      end
    end
  end

  // Drain state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= RUN;
    else         state <= state_n;
  end

  // Drain next-state: IDLE only once every credit is home and the link register is empty
  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (drain_i) state_n = DRAIN;
      DRAIN: begin
        if (!drain_i)                                    state_n = RUN;
        else if ((credits_o == full_cnt_lp) && !link.v_o) state_n = IDLE;
      end
      IDLE:    if (!drain_i) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_bsg_fifo_credit_sender.sv
// tb/tb_bsg_fifo_credit_sender.sv - directed self-checking bench for bsg_fifo_credit_sender
module tb_bsg_fifo_credit_sender;

  logic clk;
  logic rst;
  logic drain_a, idle_a, error_a;
  logic drain_b, idle_b, error_b;
  logic [2:0] credits_a, credits_b;

  int checks;
  int failures;
  int pulses;

  bsg_fifo_credit_sender_if #(.width_p(32), .els_p(4)) ifa ();
  bsg_fifo_credit_sender_if #(.width_p(32), .els_p(6)) ifb ();

  bsg_fifo_credit_sender #(.width_p(32), .els_p(4), .credit_batch_p(1)) dut_a (
    .clk_i(clk), .reset_i(rst), .link(ifa), .drain_i(drain_a),
    .idle_o(idle_a), .credits_o(credits_a), .error_o(error_a)
  );

  bsg_fifo_credit_sender #(.width_p(32), .els_p(6), .credit_batch_p(2)) dut_b (
    .clk_i(clk), .reset_i(rst), .link(ifb), .drain_i(drain_b),
    .idle_o(idle_b), .credits_o(credits_b), .error_o(error_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; pulses = 0;
    rst = 1'b1;
    drain_a = 1'b0; drain_b = 1'b0;
    ifa.v_i = 1'b0; ifa.data_i = '0; ifa.credit_i = 1'b0;
    ifb.v_i = 1'b0; ifb.data_i = '0; ifb.credit_i = 1'b0;
    tick(); tick();

    chk("rst_credits", 64'(credits_a), 64'd4);
    chk("rst_v_o", 64'(ifa.v_o), 64'd0);
    chk("rst_data_o", 64'(ifa.data_o), 64'd0);
    chk("rst_wptr_o", 64'(ifa.wptr_o), 64'd0);
    chk("rst_error", 64'(error_a), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 64'(ifa.ready_o), 64'd1);
    chk("rst_idle", 64'(idle_a), 64'd0);

    // Fill: six offered words, only four credits
    ifa.v_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ifa.data_i = 32'hA0 + 32'(k);
      tick();
      if (ifa.v_o) pulses++;
      chk("fill_v_o", 64'(ifa.v_o), (k < 4) ? 64'd1 : 64'd0);
      if (k < 4) begin
        chk("fill_data", 64'(ifa.data_o), 64'hA0 + 64'(k));
        chk("fill_wptr", 64'(ifa.wptr_o), 64'(k));
      end
      chk("fill_ready", 64'(ifa.ready_o), (k < 3) ? 64'd1 : 64'd0);
    end
    chk("fill_pulses", 64'(pulses), 64'd4);
    chk("fill_credits", 64'(credits_a), 64'd0);

    // Credit return at zero with valid held: no send this cycle
    ifa.credit_i = 1'b1; ifa.data_i = 32'hB0;
    tick();
    chk("c0_v_o", 64'(ifa.v_o), 64'd0);
    chk("c0_ready", 64'(ifa.ready_o), 64'd1);
    chk("c0_credits", 64'(credits_a), 64'd1);
    ifa.credit_i = 1'b0;
    tick();
    chk("wrap_v_o", 64'(ifa.v_o), 64'd1);
    chk("wrap_data", 64'(ifa.data_o), 64'hB0);
    chk("wrap_wptr", 64'(ifa.wptr_o), 64'd0);
    chk("wrap_credits", 64'(credits_a), 64'd0);

    // Steady state: send and credit together
    ifa.v_i = 1'b0; ifa.credit_i = 1'b1;
    tick();
    chk("ss_pre_credits", 64'(credits_a), 64'd1);
    chk("ss_pre_v_o", 64'(ifa.v_o), 64'd0);
    ifa.v_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ifa.data_i = 32'hC0 + 32'(i);
      tick();
      chk("ss_v_o", 64'(ifa.v_o), 64'd1);
      chk("ss_data", 64'(ifa.data_o), 64'hC0 + 64'(i));
      chk("ss_wptr", 64'(ifa.wptr_o), 64'((1 + i) % 4));
      chk("ss_credits", 64'(credits_a), 64'd1);
    end
    ifa.v_i = 1'b0;

    // Drain with two credits outstanding
    tick();
    chk("dr_pre_credits", 64'(credits_a), 64'd2);
    ifa.credit_i = 1'b0; drain_a = 1'b1;
    tick();
    chk("dr_ready", 64'(ifa.ready_o), 64'd0);
    chk("dr_idle0", 64'(idle_a), 64'd0);
    ifa.credit_i = 1'b1;
    tick();
    chk("dr_idle1", 64'(idle_a), 64'd0);
    tick();
    chk("dr_credits", 64'(credits_a), 64'd4);
    chk("dr_idle2", 64'(idle_a), 64'd0);
    ifa.credit_i = 1'b0;
    tick();
    chk("dr_idle", 64'(idle_a), 64'd1);
    chk("dr_idle_ready", 64'(ifa.ready_o), 64'd0);
    drain_a = 1'b0;
    tick();
    chk("dr_run_ready", 64'(ifa.ready_o), 64'd1);
    chk("dr_run_idle", 64'(idle_a), 64'd0);

    // Overflow at full credits
    ifa.credit_i = 1'b1;
    tick();
    chk("ovf_error", 64'(error_a), 64'd1);
    chk("ovf_credits", 64'(credits_a), 64'd4);
    ifa.credit_i = 1'b0;
    tick();
    chk("ovf_sticky", 64'(error_a), 64'd1);
    rst = 1'b1;
    #1;
    chk("ovf_rst_clear", 64'(error_a), 64'd0);
    rst = 1'b0;
    tick();

    // Asynchronous reset with a word on the link
    ifa.v_i = 1'b1; ifa.data_i = 32'hD0;
    tick();
    chk("ar_v_o_pre", 64'(ifa.v_o), 64'd1);
    chk("ar_credits_pre", 64'(credits_a), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_v_o", 64'(ifa.v_o), 64'd0);
    chk("ar_credits", 64'(credits_a), 64'd4);
    ifa.v_i = 1'b0;
    rst = 1'b0;
    tick();

    // Second configuration: six slots, credits return in pairs
    chk("b_rst_credits", 64'(credits_b), 64'd6);
    ifb.v_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ifb.data_i = 32'hE0 + 32'(k);
      tick();
      chk("b_v_o", 64'(ifb.v_o), 64'd1);
      chk("b_wptr", 64'(ifb.wptr_o), 64'(k));
      chk("b_credits", 64'(credits_b), 64'(5 - k));
    end
    ifb.v_i = 1'b0;
    tick();
    chk("b_empty_ready", 64'(ifb.ready_o), 64'd0);
    chk("b_empty_v_o", 64'(ifb.v_o), 64'd0);
    ifb.credit_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("b_ret_credits", 64'(credits_b), 64'(2 * (j + 1)));
    end
    ifb.credit_i = 1'b0;
    chk("b_error", 64'(error_b), 64'd0);
    ifb.v_i = 1'b1; ifb.data_i = 32'hF0;
    tick();
    chk("b_wrap_wptr", 64'(ifb.wptr_o), 64'd0);
    chk("b_wrap_data", 64'(ifb.data_o), 64'hF0);
    ifb.v_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
